// File: rtl/data_transfer_buffer.sv
// Buffered start/end transfer stage: FIFO capture on start_ev, latency-timed end_ev presentation.
// Optional TRANSFER_COUNT_EN adds a saturating handshake counter on xfer_count.
module data_transfer_buffer #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_ev,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     out_ready,
  output logic                     end_ev,
  output logic [DATA_W-1:0]        out_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef TRANSFER_COUNT_EN
  ,
  output logic [15:0]              xfer_count
`endif
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int LAT_LOAD = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam int LAT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam bit LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_overflow;
  logic                r_end_ev;
  logic [DATA_W-1:0]   r_out_data;
  logic [LAT_W-1:0]    r_lat;

  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    w_old_left;
  logic [PTR_W-1:0]    w_rd_next;
  logic [DATA_W-1:0]   w_head;

  assign w_push     = start_ev & ~r_full;
  assign w_pop      = (r_state == S_PRESENT) & out_ready;
  assign w_cnt_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_old_left = r_count - CNT_W'(w_pop);
  assign w_rd_next  = r_rd_ptr + PTR_W'(w_pop);
  // When no stored word survives this edge, the next head is the word being pushed now.
  assign w_head     = (w_old_left == '0) ? in_data : r_mem[w_rd_next];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_next;
      r_full   <= (w_cnt_next == CNT_W'(DEPTH));
      if (start_ev && r_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_end_ev   <= 1'b0;
      r_out_data <= '0;
      r_lat      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cnt_next != '0) begin
            if (LAT_ONE) begin
              r_state    <= S_PRESENT;
              r_end_ev   <= 1'b1;
              r_out_data <= w_head;
            end else begin
              r_state <= S_WAIT;
              r_lat   <= LAT_W'(LAT_LOAD);
            end
          end
        end
        S_WAIT: begin
          if (r_lat == '0) begin
            r_state    <= S_PRESENT;
            r_end_ev   <= 1'b1;
            r_out_data <= w_head;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            if (w_cnt_next == '0) begin
              r_state  <= S_IDLE;
              r_end_ev <= 1'b0;
            end else if (LAT_ONE) begin
              r_out_data <= w_head;
            end else begin
              r_state  <= S_WAIT;
              r_end_ev <= 1'b0;
              r_lat    <= LAT_W'(LAT_LOAD);
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_end_ev <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRANSFER_COUNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (w_pop && (r_xfer_count != 16'hFFFF)) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

  assign end_ev   = r_end_ev;
  assign out_data = r_out_data;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_data_transfer_buffer.sv
// Self-checking bench for data_transfer_buffer: queue-based timing model plus directed literal checks.
module tb_data_transfer_buffer;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start_ev = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              end_ev;
  logic [DATA_W-1:0] out_data;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
`ifdef TRANSFER_COUNT_EN
  logic [15:0]       xfer_count;
`endif

  always #5 clock = ~clock;

  data_transfer_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset), .start_ev(start_ev), .in_data(in_data),
    .out_ready(out_ready), .end_ev(end_ev), .out_data(out_data), .full(full),
    .count(count), .overflow(overflow)
`ifdef TRANSFER_COUNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus the cycle at which the head must appear.
  logic [63:0] q[$];
  bit          m_pres = 1'b0;
  longint      m_due  = -1;
  longint      m_cyc  = 0;
  logic [63:0] m_out  = '0;
  bit          m_ovf  = 1'b0;
  int          m_xfer = 0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        q.delete();
        m_pres = 1'b0;
        m_due  = -1;
        m_out  = '0;
        m_ovf  = 1'b0;
        m_xfer = 0;
      end else begin
        bit hs;
        bit pushok;
        hs     = m_pres && out_ready;
        pushok = start_ev && (q.size() < DEPTH);
        if (start_ev && q.size() == DEPTH) m_ovf = 1'b1;
        if (hs) begin
          void'(q.pop_front());
          m_pres = 1'b0;
          if (m_xfer < 65535) m_xfer++;
        end
        if (pushok) q.push_back(in_data);
        if (hs) m_due = (q.size() > 0) ? m_cyc + LATENCY : -1;
        else if (!m_pres && m_due < 0 && q.size() > 0) m_due = m_cyc + LATENCY;
        if (!m_pres && m_due == m_cyc + 1) begin
          m_pres = 1'b1;
          m_out  = q[0];
          m_due  = -1;
        end
        m_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("end_ev", 64'(end_ev), 64'(m_pres));
      chk("out_data", out_data, m_out);
      chk("count", 64'(count), 64'(q.size()));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef TRANSFER_COUNT_EN
      chk("xfer_count", 64'(xfer_count), 64'(m_xfer));
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_end();
    for (int t = 0; t < 20 && !end_ev; t++) step();
    chk("wait_end_timeout", 64'(end_ev), 64'd1);
  endtask

  task automatic push1(input logic [63:0] d);
    step();
    start_ev = 1'b1;
    in_data  = d;
  endtask

  task automatic drain(input int n, input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] w2, input logic [63:0] w3, input string tag);
    int got;
    int last;
    logic [63:0] e;
    got  = 0;
    last = -1;
    out_ready = 1'b1;
    for (int t = 0; t < 60 && got < n; t++) begin
      if (end_ev) begin
        case (got)
          0: e = w0;
          1: e = w1;
          2: e = w2;
          default: e = w3;
        endcase
        chk({tag, "_word"}, out_data, e);
        if (last >= 0) chk({tag, "_gap"}, 64'(t - last), 64'(LATENCY));
        last = t;
        got++;
      end
      step();
    end
    chk({tag, "_words_seen"}, 64'(got), 64'(n));
    out_ready = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_end_ev", 64'(end_ev), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    step(); step();
    reset = 1'b0;
    step(); step();

    // single transfer with out_ready held high
    out_ready = 1'b1;
    push1(64'hDEAD_BEEF_0123_4567);
    step();
    start_ev = 1'b0;
    chk("single_no_early_end", 64'(end_ev), 64'd0);
    chk("single_count1", 64'(count), 64'd1);
    step();
    chk("single_end_ev", 64'(end_ev), 64'd1);
    chk("single_data", out_data, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("single_end_drop", 64'(end_ev), 64'd0);
    chk("single_count0", 64'(count), 64'd0);

    // backpressure: hold for five cycles, pop on the fifth
    out_ready = 1'b0;
    push1(64'h1111_2222_3333_4444);
    step();
    start_ev = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_end_held", 64'(end_ev), 64'd1);
      chk("bp_data_held", out_data, 64'h1111_2222_3333_4444);
      if (i == 4) out_ready = 1'b1;
      step();
    end
    chk("bp_end_after_pop", 64'(end_ev), 64'd0);
    out_ready = 1'b0;

    // fill and overflow, then drain in order
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 5) chk("fill_full_after_4", 64'(full), 64'd1);
      start_ev = 1'b1;
      in_data  = 64'(k);
    end
    step();
    start_ev = 1'b0;
    chk("fill_count4", 64'(count), 64'd4);
    chk("fill_overflow", 64'(overflow), 64'd1);
    drain(4, 64'd1, 64'd2, 64'd3, 64'd4, "drain");
    chk("drain_empty", 64'(count), 64'd0);

    // simultaneous push and pop at count 2
    push1(64'd10);
    push1(64'd20);
    step();
    start_ev = 1'b0;
    wait_end();
    chk("simul_head", out_data, 64'd10);
    start_ev  = 1'b1;
    in_data   = 64'd30;
    out_ready = 1'b1;
    step();
    start_ev = 1'b0;
    chk("simul_count2", 64'(count), 64'd2);
    drain(2, 64'd20, 64'd30, 64'd0, 64'd0, "simul");

    // reset while presenting with three stored words
    for (int k = 1; k <= 5; k++) push1(64'(k + 100));
    step();
    start_ev = 1'b0;
    wait_end();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_end();
    chk("pre_rst_count3", 64'(count), 64'd3);
    chk("pre_rst_overflow", 64'(overflow), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_end_ev", 64'(end_ev), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_full", 64'(full), 64'd0);
    chk("async_rst_overflow", 64'(overflow), 64'd0);
    step();
    reset = 1'b0;
    push1(64'hA5);
    step();
    start_ev = 1'b0;
    chk("post_rst_no_early", 64'(end_ev), 64'd0);
    step();
    chk("post_rst_end_ev", 64'(end_ev), 64'd1);
    chk("post_rst_data", out_data, 64'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef TRANSFER_COUNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push1(64'(k + 7));
      step();
      start_ev = 1'b0;
      wait_end();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("xfer_three", 64'(xfer_count), 64'd3);
    dut.r_xfer_count = 16'hFFFE;
    m_xfer = 65534;
    for (int k = 0; k < 3; k++) begin
      push1(64'(k + 70));
      step();
      start_ev = 1'b0;
      wait_end();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("xfer_saturate", 64'(xfer_count), 64'hFFFF);
`endif

    // randomized traffic with varying push and ready densities
    for (int i = 0; i < 3000; i++) begin
      step();
      start_ev  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 25));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 99) < ((i / 300) % 3 == 0 ? 20 : 75));
      if (i == 1500) reset = 1'b1;
      if (i == 1502) reset = 1'b0;
    end
    step();
    start_ev  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_transfer_buffer.md
Name: data_transfer_buffer

Overview:
- Buffered transfer stage that produces the start/end transaction stream the data-legality checkers observe.
- Each `start_ev` captures `in_data` into a FIFO. After a fixed latency, the stage presents that word on `out_data` with `end_ev` asserted, and holds it until the downstream consumer takes it with `out_ready`.
- Contract: the word on `out_data` while `end_ev` is high always equals the `in_data` captured at the matching `start_ev`, in order.

Parameters:
- DATA_W, 64, width of in_data/out_data.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- LATENCY, 2, cycles from an accepted start_ev (empty FIFO, idle output) to first end_ev; >= 1.

Ports:
- clock  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- start_ev  input  1  capture request; in_data sampled this cycle.
- in_data  input  DATA_W  word captured on accepted start_ev.
- out_ready  input  1  consumer takes presented word when high with end_ev.
- end_ev  output  1  word on out_data valid; held until out_ready.
- out_data  output  DATA_W  head word; stable while end_ev high.
- full  output  1  registered; count == DEPTH.
- count  output  $clog2(DEPTH)+1  registered occupancy.
- overflow  output  1  sticky; start_ev seen while full.

Behaviour:
- Reset (async assert, sync-safe deassert path):
  - end_ev=0, out_data=0, full=0, count=0, overflow=0.
  - FIFO pointers=0, FSM=IDLE.
  - Reset mid-transfer discards all stored words and any presented word.
- Push:
  - When start_ev && !full: write in_data at the write pointer; the pointer wraps modulo DEPTH.
  - full and count are the registered values. No same-cycle bypass: a push while full is dropped even if a pop occurs that cycle.
- Drop:
  - When start_ev && full: the word is discarded, the FIFO is unchanged, and overflow is set to 1 next cycle.
  - overflow stays 1 until reset.
- Pop: the handshake is end_ev && out_ready. The read pointer advances and wraps modulo DEPTH.
- count:
  - +1 on push only; -1 on pop only; unchanged on push and pop in the same cycle.
  - Never exceeds DEPTH and never underflows.
- Output FSM, states IDLE, WAIT, PRESENT:
  - IDLE:
    - If count>0, or an accepted push this cycle: go to WAIT, with the latency counter loaded so that end_ev rises exactly LATENCY cycles after that cycle.
    - With LATENCY==1, go directly to PRESENT.
  - WAIT: decrement the counter; at terminal count, go to PRESENT.
  - PRESENT:
    - end_ev=1; out_data = FIFO head.
    - On out_ready: pop. If entries remain after the pop, go to WAIT (next end_ev LATENCY cycles after the handshake cycle); otherwise go to IDLE.
    - Without out_ready: stay in PRESENT, data held.
- out_data is registered, loaded on entry to PRESENT, and holds its last value after the pop. Consumers qualify it with end_ev.
- Ordering: strict FIFO; no word is duplicated or lost except on a drop.

Optional Feature:
- Macro: TRANSFER_COUNT_EN.
- Defined:
  - Adds output xfer_count [15:0].
  - Incremented on each pop handshake; saturates at 16'hFFFF.
  - Reset to 0 asynchronously.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Single transfer, LATENCY=2:
  - Stimulus: start_ev at cycle 5 with in_data=64'hDEAD_BEEF_0123_4567; out_ready held 1.
  - Response: end_ev=1 only in cycle 7, with out_data=64'hDEAD_BEEF_0123_4567; count 1 then 0.
- Backpressure:
  - Stimulus: same push, out_ready=0 for 4 cycles after end_ev rises.
  - Response: end_ev and out_data held for 5 cycles; pop on the 5th.
- Fill and overflow, DEPTH=4, out_ready=0:
  - Stimulus: 5 start_ev with data 1,2,3,4,5.
  - Response: full=1 after the 4th; word 5 dropped; overflow=1.
  - Drain: with out_ready=1, outputs appear as 1,2,3,4, each spaced LATENCY cycles after the previous handshake.
- Simultaneous push and pop at count=2: count stays 2, and FIFO order is preserved.
- Reset mid-operation:
  - Stimulus: assert reset while in PRESENT with count=3.
  - Response: end_ev, count, full and overflow go to 0 immediately (async); after release, a new push with data=64'hA5 emerges LATENCY cycles later.
- TRANSFER_COUNT_EN: after 3 handshakes xfer_count=3; preload near max to check it saturates at 16'hFFFF.
